// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: N_IN-way request arbiter that feeds a single registered
// output slot. It uses fixed priority (lowest index wins) when RR_MODE=0 and
// round-robin when RR_MODE=1.
// Optional build macro DCACHE_REQ_ARB_PERF_EN adds the io_perf_conflict counter.
module dcache_req_arbiter #(
  parameter int N_IN    = 4,
  parameter int WAY_W   = 8,
  parameter int ADDR_W  = 36,
  parameter int RR_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_IN-1:0]           io_in_valid,
  output logic [N_IN-1:0]           io_in_ready,
  input  logic [N_IN*WAY_W-1:0]     io_in_way_en,
  input  logic [N_IN*ADDR_W-1:0]    io_in_addr,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [WAY_W-1:0]          io_out_way_en,
  output logic [ADDR_W-1:0]         io_out_addr,
  output logic [$clog2(N_IN)-1:0]   io_out_chosen
`ifdef DCACHE_REQ_ARB_PERF_EN
  ,
  output logic [31:0]               io_perf_conflict
`endif
);

  localparam int IDX_W = $clog2(N_IN);

  logic              out_valid_q, out_valid_d;
  logic [WAY_W-1:0]  out_way_q, out_way_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [IDX_W-1:0]  out_chosen_q, out_chosen_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [IDX_W-1:0]  start_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              found;
  logic [N_IN-1:0]   grant;
  logic              en;
  logic              xfer;

  // Priority search that starts at start_ptr and wraps at N_IN-1. In fixed
  // mode the search always starts at 0.
  always_comb begin
    logic [IDX_W:0] cand;
    start_ptr = (RR_MODE != 0) ? ptr_q : '0;
    grant     = '0;
    win_idx   = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, start_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_IN)) begin
        cand = cand - (IDX_W+1)'(N_IN);
      end
      if (!found && io_in_valid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    grant[win_idx] = found;
  end

  // Load enable, handshake back to requesters, and the next output slot.
  always_comb begin
    en           = !out_valid_q || io_out_ready;
    xfer         = en && found;
    io_in_ready  = reset ? '0 : (grant & {N_IN{en}});
    out_valid_d  = out_valid_q;
    out_way_d    = out_way_q;
    out_addr_d   = out_addr_q;
    out_chosen_d = out_chosen_q;
    ptr_d        = ptr_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_way_d    = io_in_way_en[int'(win_idx)*WAY_W +: WAY_W];
      out_addr_d   = io_in_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      out_chosen_d = win_idx;
      if (RR_MODE != 0) begin
        ptr_d = (win_idx == IDX_W'(N_IN-1)) ? '0 : win_idx + IDX_W'(1);
      end
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and round-robin pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_way_q    <= '0;
      out_addr_q   <= '0;
      out_chosen_q <= '0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_way_q    <= out_way_d;
      out_addr_q   <= out_addr_d;
      out_chosen_q <= out_chosen_d;
      ptr_q        <= ptr_d;
    end
  end

  assign io_out_valid  = out_valid_q;
  assign io_out_way_en = out_way_q;
  assign io_out_addr   = out_addr_q;
  assign io_out_chosen = out_chosen_q;

`ifdef DCACHE_REQ_ARB_PERF_EN
  logic [31:0]    conflict_q, conflict_d;
  logic [IDX_W:0] n_valid;

  // Count transfer cycles that had competing requesters, saturating.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < N_IN; i++) begin
      n_valid = n_valid + (IDX_W+1)'(io_in_valid[i]);
    end
    conflict_d = conflict_q;
    if (xfer && n_valid >= (IDX_W+1)'(2) && conflict_q != 32'hFFFF_FFFF) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clock) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign io_perf_conflict = conflict_q;
`endif

endmodule
